// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: default width and FSM state encoding.
package timer_pkg;

  localparam int TIMER_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, abort, retrigger and optional auto-reload;
// emits a one-cycle done pulse at terminal count. All outputs are registered.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = TIMER_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_paused;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_done_nxt;
  logic             w_load_zero;
  logic             w_last;

  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign w_load_zero = (load_val == '0);
  // Treat 0 like 1 so a stray zero in RUN still terminates instead of sticking.
  assign w_last      = (r_cnt <= WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (start) begin
      w_state_nxt = w_load_zero ? ST_IDLE : ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_last && !AUTO_RELOAD) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: w_state_nxt = pause ? ST_PAUSE : ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (abort) begin
      w_cnt_nxt = '0;
    end else if (start) begin
      w_cnt_nxt    = load_val;
      w_reload_nxt = load_val;
      w_done_nxt   = w_load_zero;
    end else if (r_state == ST_RUN && !pause) begin
      if (w_last) begin
        w_done_nxt = 1'b1;
        w_cnt_nxt  = AUTO_RELOAD ? r_reload : '0;
      end else begin
        w_cnt_nxt = dec_sat(r_cnt);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_paused <= (w_state_nxt == ST_PAUSE);
    end
  end

  assign cnt    = r_cnt;
  assign busy   = r_busy;
  assign paused = r_paused;
  assign done   = r_done;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing counterpart to the team's free-running 4-bit up-counter.
- Counts a programmed value down to zero and signals terminal count with a one-cycle `done` pulse.
- Supports pause, abort, retrigger and optional auto-reload.
- Sits beside the up-counter as the timeout/delay generator for control FSMs.

Parameters:
- WIDTH, 4, bit width of `load_val` and `cnt`.
- AUTO_RELOAD, 0, 1 = reload the latched value at terminal count and keep running; 0 = return to IDLE.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_val  input  WIDTH  count value sampled when `start` is high.
- start  input  1  load `load_val` and begin counting; retriggers if already running.
- pause  input  1  freeze the count while high; RUN and PAUSE states only.
- abort  input  1  stop immediately and clear; no `done` pulse.
- cnt  output  WIDTH  current remaining count.
- busy  output  1  high in RUN or PAUSE.
- paused  output  1  high in PAUSE.
- done  output  1  one-cycle pulse at terminal count.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high on `reset`.
- All outputs are registered.
- Reset values: cnt=0, busy=0, paused=0, done=0, state=IDLE, reload register=0.
- States:
  - IDLE
  - RUN
  - PAUSE
- Input priority, evaluated each rising edge: reset > abort > start > pause > decrement.
- IDLE:
  - start with load_val≠0: cnt<=load_val, reload<=load_val, go to RUN.
  - start with load_val=0: done pulses for the following cycle; stay in IDLE with cnt=0.
- RUN:
  - pause=1: go to PAUSE; cnt holds.
  - Otherwise, cnt>1: cnt<=cnt-1.
  - Otherwise, cnt=1: cnt<=0, done<=1.
    - AUTO_RELOAD=0: go to IDLE.
    - AUTO_RELOAD=1: cnt<=reload instead of 0; stay in RUN.
- PAUSE:
  - cnt holds.
  - pause=0: return to RUN; decrementing resumes on the next edge.
- Retrigger: start in RUN or PAUSE reloads cnt and reload from load_val and enters RUN.
  - No done pulse for the interrupted count.
  - start overrides pause in that cycle.
  - If this start has load_val=0, it behaves as the IDLE zero-load case.
- abort in any state: cnt<=0, go to IDLE, done=0.
  - abort and start together: abort wins.
- Latency: start sampled at edge k with load_val=N≥1 gives done high during the cycle after edge k+N, with cnt=0 in that cycle when AUTO_RELOAD=0.
  - Each paused cycle adds one cycle.
- Auto-reload period: N cycles between done pulses; busy stays high.
- No wrap-around: cnt never decrements below 0.
- All arithmetic is unsigned, WIDTH bits. load_val max = 2^WIDTH-1.
- done is never high for two consecutive cycles, except with AUTO_RELOAD=1 and N=1, where it is high every cycle.
- Reset mid-count: all state is cleared on the next edge and no done pulse is produced.

Decomposition:
- Shared package `timer_pkg`:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - Default WIDTH.
- Single module, no sub-module needed.
  - The FSM and datapath are small enough to stay in one module.
  - The next-count logic may optionally be split into a combinational `dec_sat` helper (saturating decrement).

Test Plan:
- Basic count: reset, then start with load_val=5 → cnt sequence 5,4,3,2,1,0; done high only in the cycle cnt first reads 0; busy falls in that same cycle.
- Pause: load 4, assert pause for 3 cycles after cnt=3 → cnt holds 3 for 3 cycles with paused=1; done arrives 3 cycles later than in the unpaused case.
- Retrigger and abort:
  - At cnt=2, start with load_val=9 → cnt=9 next cycle and no done pulse.
  - Abort at cnt=6 → cnt=0, busy=0, done never asserted.
- Auto-reload (AUTO_RELOAD=1), load_val=3 → done every 3rd cycle and cnt cycles 3,2,1,3,2,1; run ≥3 periods.
- Edges:
  - load_val=0 start → single done pulse, busy stays 0.
  - load_val=15 with WIDTH=4 → 15 cycles to done, no underflow.
  - Simultaneous abort+start → IDLE.
- Reset mid-run at cnt=7 → all outputs 0 on the next edge; counting stays stopped until the next start.
